// File: rtl/z_result_stage.sv
// z_result_stage
// Captures the 64-bit ALU result into the ZHi/ZLo register pair.
// For MUL/DIV it first waits a programmable number of settle cycles.
// It then presents the result on the 32-bit bus as a ZLo beat,
// followed by a ZHi beat for 64-bit ops.
//
// Parameters:
//   MULDIV_WAIT  settle cycles before capture for MUL (5'b01111) / DIV (5'b10000), 0..15
//   OTHER_WAIT   settle cycles before capture for every other opcode, 0..15
//
// Ports:
//   clk          clock, rising edge
//   clr          asynchronous active-low reset
//   start        one-cycle capture request, honoured only while busy=0
//   opcode       ALU opcode driving alu_result
//   alu_result   ALU C_out; [31:0] low/quotient, [63:32] high/remainder
//   busy         operation in flight (WAIT/CAPT/SEND_LO/SEND_HI)
//   z_lo, z_hi   Z register pair, held until the next capture
//   bus_data     beat data, zero when bus_valid=0
//   bus_valid    beat valid
//   bus_ready    consumer ready
//   bus_last     final beat of a result
//   illegal      sticky: ALU default pattern captured with an undecoded opcode
//   flag_z       (Z_FLAGS_EN only) captured {z_hi,z_lo} == 0
//   flag_n       (Z_FLAGS_EN only) sign of the captured result
//   dbg_state_o  current FSM state, for observation only
//
// Handshake: a beat transfers on a rising edge where bus_valid & bus_ready.
// While bus_valid=1 and bus_ready=0, bus_data and bus_last are held stable.
//
// Optional feature macro: Z_FLAGS_EN (adds flag_z / flag_n).
module z_result_stage #(
  parameter int unsigned MULDIV_WAIT = 2,
  parameter int unsigned OTHER_WAIT  = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [63:0] alu_result,
  output logic        busy,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic [31:0] bus_data,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_last,
  output logic        illegal,
`ifdef Z_FLAGS_EN
  output logic        flag_z,
  output logic        flag_n,
`endif
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPT    = 3'd2,
    S_SEND_LO = 3'd3,
    S_SEND_HI = 3'd4
  } state_t;

  localparam logic [3:0] MD_N = 4'(MULDIV_WAIT);
  localparam logic [3:0] OT_N = 4'(OTHER_WAIT);

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b10000);
  endfunction

  // Opcodes the ALU decodes; anything else makes the ALU drive all ones.
  function automatic logic is_decoded(input logic [4:0] op);
    return ((op >= 5'd3) && (op <= 5'd10)) || ((op >= 5'd12) && (op <= 5'd18));
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] zlo_q, zlo_d;
  logic [31:0] zhi_q, zhi_d;
  logic        ill_q, ill_d;
  logic [3:0]  start_n;
  logic        op_md;

  // Settle count chosen from the incoming opcode, since op_q is being
  // written on the same edge.
  assign start_n = is_muldiv(opcode) ? MD_N : OT_N;
  assign op_md   = is_muldiv(op_q);

`ifdef Z_FLAGS_EN
  logic fz_q, fz_d;
  logic fn_q, fn_d;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      zlo_q   <= '0;
      zhi_q   <= '0;
      ill_q   <= 1'b0;
`ifdef Z_FLAGS_EN
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      ill_q   <= ill_d;
`ifdef Z_FLAGS_EN
      fz_q    <= fz_d;
      fn_q    <= fn_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    zlo_d     = zlo_q;
    zhi_d     = zhi_q;
    ill_d     = ill_q;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    bus_data  = '0;
`ifdef Z_FLAGS_EN
    fz_d      = fz_q;
    fn_d      = fn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = opcode;
          if (start_n != 4'd0) begin
            // The counter holds the remaining WAIT cycles after this one.
            cnt_d   = start_n - 4'd1;
            state_d = S_WAIT;
          end else begin
            state_d = S_CAPT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPT: begin
        zlo_d = alu_result[31:0];
        zhi_d = op_md ? alu_result[63:32] : 32'd0;
        if ((alu_result == {64{1'b1}}) && !is_decoded(op_q)) begin
          ill_d = 1'b1;
        end
`ifdef Z_FLAGS_EN
        fz_d = (alu_result[31:0] == 32'd0) &&
               (!op_md || (alu_result[63:32] == 32'd0));
        fn_d = op_md ? alu_result[63] : alu_result[31];
`endif
        state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        bus_valid = 1'b1;
        bus_data  = zlo_q;
        bus_last  = !op_md;
        if (bus_ready) begin
          state_d = op_md ? S_SEND_HI : S_IDLE;
        end
      end
      S_SEND_HI: begin
        bus_valid = 1'b1;
        bus_data  = zhi_q;
        bus_last  = 1'b1;
        if (bus_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign z_lo        = zlo_q;
  assign z_hi        = zhi_q;
  assign illegal     = ill_q;
  assign dbg_state_o = state_q;
`ifdef Z_FLAGS_EN
  assign flag_z      = fz_q;
  assign flag_n      = fn_q;
`endif

endmodule
